// File: rtl/pulse_width_meter_if.sv
// Edge-pulse inputs and width result handshake for pulse_width_meter.
// drop_count_o exists only when PULSE_WIDTH_METER_DROP_CNT_EN is defined.
interface pulse_width_meter_if #(
    parameter int CNT_W = 16
);
    logic             rising_edge_i;
    logic             falling_edge_i;
    logic [CNT_W-1:0] width_o;
    logic             overflow_o;
    logic             width_valid_o;
    logic             width_ready_i;
    logic             dropped_o;
`ifdef PULSE_WIDTH_METER_DROP_CNT_EN
    logic [7:0]       drop_count_o;
`endif

    // master: edge source and result consumer; slave: the meter
    modport master (
        output rising_edge_i, falling_edge_i, width_ready_i,
        input  width_o, overflow_o, width_valid_o, dropped_o
`ifdef PULSE_WIDTH_METER_DROP_CNT_EN
        , input drop_count_o
`endif
    );

    modport slave (
        input  rising_edge_i, falling_edge_i, width_ready_i,
        output width_o, overflow_o, width_valid_o, dropped_o
`ifdef PULSE_WIDTH_METER_DROP_CNT_EN
        , output drop_count_o
`endif
    );
endinterface

// File: rtl/pulse_width_meter.sv
// Measures high time (cycles) from upstream edge pulses; one-entry result holding register.
// Optional saturating drop counter enabled by PULSE_WIDTH_METER_DROP_CNT_EN.
module pulse_width_meter #(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    pulse_width_meter_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, MEAS} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             dropped_q, dropped_d;
    logic             capture;
    logic             drop;
    logic             rise;
    logic             fall;

    // Simultaneous edges are illegal upstream and are treated as no edge.
    assign rise = bus.rising_edge_i & ~bus.falling_edge_i;
    assign fall = bus.falling_edge_i & ~bus.rising_edge_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEAS;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    sat_d   = 1'b0;
                end
            end
            MEAS: begin
                if (fall) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else if (rise) begin
                    cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                    sat_d = 1'b0;
                end else if (cnt_q == CNT_MAX) begin
                    sat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        width_d   = width_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        dropped_d = dropped_q;
        drop      = 1'b0;
        if (capture) begin
            // A pending result leaving this cycle frees the register for the new one.
            if (!valid_q || bus.width_ready_i) begin
                width_d = cnt_q;
                ovf_d   = sat_q;
                valid_d = 1'b1;
            end else begin
                drop      = 1'b1;
                dropped_d = 1'b1;
            end
        end else if (valid_q && bus.width_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            width_q   <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            width_q   <= width_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.width_o       = width_q;
    assign bus.overflow_o    = ovf_q;
    assign bus.width_valid_o = valid_q;
    assign bus.dropped_o     = dropped_q;

`ifdef PULSE_WIDTH_METER_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 8'hFF)
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) drop_cnt_q <= 8'd0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign bus.drop_count_o = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed self-checking bench: a 16-bit meter for general behaviour, a 4-bit meter for saturation.
module tb_pulse_width_meter;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    pulse_width_meter_if #(.CNT_W(16)) a16 ();
    pulse_width_meter_if #(.CNT_W(4))  a4 ();

    pulse_width_meter #(.CNT_W(16)) u_dut (.clk(clk), .reset(reset), .bus(a16.slave));
    pulse_width_meter #(.CNT_W(4))  u_sat (.clk(clk), .reset(reset), .bus(a4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rise(input bit s4, input logic v);
        if (s4) a4.rising_edge_i = v; else a16.rising_edge_i = v;
    endtask

    task automatic set_fall(input bit s4, input logic v);
        if (s4) a4.falling_edge_i = v; else a16.falling_edge_i = v;
    endtask

    // Rising pulse, w-1 quiet cycles, falling pulse; returns just after the falling edge is sampled.
    task automatic pulse(input bit s4, input int w);
        set_rise(s4, 1'b1);
        step();
        set_rise(s4, 1'b0);
        repeat (w - 1) step();
        set_fall(s4, 1'b1);
        step();
        set_fall(s4, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        a16.rising_edge_i = 1'b0; a16.falling_edge_i = 1'b0; a16.width_ready_i = 1'b1;
        a4.rising_edge_i  = 1'b0; a4.falling_edge_i  = 1'b0; a4.width_ready_i  = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(a16.width_valid_o), 32'd0);
        chk("rst_width", 32'(a16.width_o), 32'd0);
        chk("rst_ovf", 32'(a16.overflow_o), 32'd0);
        chk("rst_dropped", 32'(a16.dropped_o), 32'd0);
`ifdef PULSE_WIDTH_METER_DROP_CNT_EN
        chk("rst_drop_cnt", 32'(a16.drop_count_o), 32'd0);
`endif
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_valid", 32'(a16.width_valid_o), 32'd0);
        end

        // Basic widths with ready held high
        pulse(1'b0, 1);
        chk("w1_valid", 32'(a16.width_valid_o), 32'd1);
        chk("w1_width", 32'(a16.width_o), 32'd1);
        chk("w1_ovf", 32'(a16.overflow_o), 32'd0);
        step();
        chk("w1_valid_clr", 32'(a16.width_valid_o), 32'd0);
        pulse(1'b0, 3);
        chk("w3_valid", 32'(a16.width_valid_o), 32'd1);
        chk("w3_width", 32'(a16.width_o), 32'd3);
        chk("w3_ovf", 32'(a16.overflow_o), 32'd0);
        step();
        pulse(1'b0, 100);
        chk("w100_valid", 32'(a16.width_valid_o), 32'd1);
        chk("w100_width", 32'(a16.width_o), 32'd100);
        chk("w100_ovf", 32'(a16.overflow_o), 32'd0);
        step();
        chk("w100_valid_clr", 32'(a16.width_valid_o), 32'd0);

        // Saturation on the 4-bit meter
        pulse(1'b1, 20);
        chk("sat_valid", 32'(a4.width_valid_o), 32'd1);
        chk("sat_width", 32'(a4.width_o), 32'd15);
        chk("sat_ovf", 32'(a4.overflow_o), 32'd1);
        step();
        pulse(1'b1, 15);
        chk("w15_width", 32'(a4.width_o), 32'd15);
        chk("w15_ovf", 32'(a4.overflow_o), 32'd0);
        step();
        pulse(1'b1, 5);
        chk("sat5_width", 32'(a4.width_o), 32'd5);
        chk("sat5_ovf", 32'(a4.overflow_o), 32'd0);
        step();

        // Simultaneous edges inside a pulse count as a plain cycle
        a16.rising_edge_i = 1'b1; step(); a16.rising_edge_i = 1'b0;
        step();
        a16.rising_edge_i = 1'b1; a16.falling_edge_i = 1'b1; step();
        a16.rising_edge_i = 1'b0; a16.falling_edge_i = 1'b0;
        chk("both_no_result", 32'(a16.width_valid_o), 32'd0);
        step();
        step();
        a16.falling_edge_i = 1'b1; step(); a16.falling_edge_i = 1'b0;
        chk("both_width", 32'(a16.width_o), 32'd5);
        chk("both_valid", 32'(a16.width_valid_o), 32'd1);
        step();

        // Backpressure and drop
        a16.width_ready_i = 1'b0;
        pulse(1'b0, 4);
        chk("bp4_width", 32'(a16.width_o), 32'd4);
        step();
        pulse(1'b0, 6);
        chk("bp6_valid", 32'(a16.width_valid_o), 32'd1);
        chk("bp6_width_held", 32'(a16.width_o), 32'd4);
        chk("bp6_dropped", 32'(a16.dropped_o), 32'd1);
`ifdef PULSE_WIDTH_METER_DROP_CNT_EN
        chk("bp6_drop_cnt", 32'(a16.drop_count_o), 32'd1);
`endif
        step();
        chk("bp_hold_width", 32'(a16.width_o), 32'd4);
        a16.width_ready_i = 1'b1;
        step();
        a16.width_ready_i = 1'b0;
        chk("bp_xfer_valid_clr", 32'(a16.width_valid_o), 32'd0);
        chk("bp_dropped_sticky", 32'(a16.dropped_o), 32'd1);

        // Concurrent transfer and capture, starting from a clean reset
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst2_dropped", 32'(a16.dropped_o), 32'd0);
        pulse(1'b0, 7);
        chk("cc7_width", 32'(a16.width_o), 32'd7);
        a16.rising_edge_i = 1'b1; step(); a16.rising_edge_i = 1'b0;
        step();
        a16.falling_edge_i = 1'b1; a16.width_ready_i = 1'b1; step();
        a16.falling_edge_i = 1'b0;
        chk("cc_width", 32'(a16.width_o), 32'd2);
        chk("cc_valid", 32'(a16.width_valid_o), 32'd1);
        chk("cc_dropped", 32'(a16.dropped_o), 32'd0);
        step();
        chk("cc_valid_clr", 32'(a16.width_valid_o), 32'd0);

        // Falling pulse in IDLE yields nothing
        a16.falling_edge_i = 1'b1; step(); a16.falling_edge_i = 1'b0;
        step();
        chk("idle_fall_valid", 32'(a16.width_valid_o), 32'd0);

        // Rising pulse in MEAS restarts the count
        a16.rising_edge_i = 1'b1; step(); a16.rising_edge_i = 1'b0;
        step();
        step();
        pulse(1'b0, 5);
        chk("restart_width", 32'(a16.width_o), 32'd5);
        chk("restart_valid", 32'(a16.width_valid_o), 32'd1);
        step();

        // Reset mid-pulse abandons it
        a16.rising_edge_i = 1'b1; step(); a16.rising_edge_i = 1'b0;
        step();
        step();
        reset = 1'b1; step(); reset = 1'b0;
        a16.falling_edge_i = 1'b1; step(); a16.falling_edge_i = 1'b0;
        chk("rst_mid_valid", 32'(a16.width_valid_o), 32'd0);
        step();
        chk("rst_mid_valid2", 32'(a16.width_valid_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
